// File: rtl/dbus_uart_tx_if.sv
// Data-bus request signals shared between the core (master) and the UART
// transmitter (slave). The bidirectional data lines stay a plain inout port
// on the slave so the tristate resolves at the pin level.
interface dbus_uart_tx_if;
    logic [15:0] dAddr;
    logic        nRW;
    logic        ioSel;

    modport master (
        output dAddr,
        output nRW,
        input  ioSel
    );

    modport slave (
        input  dAddr,
        input  nRW,
        output ioSel
    );
endinterface

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// A 4-byte register window holds TXDATA (+0) and STATUS (+2). Stores to
// TXDATA are queued in a small FIFO; a four-state FSM serialises each byte
// LSB first on a registered, glitch-free txd line.
module dbus_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          BAUD_DIV   = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    dbus_uart_tx_if.slave bus,
    inout  wire  [15:0]  dData,
    output logic         txd,
    output logic         txBusy
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        ioSel;
    logic        wrSel;
    logic        wrSelQReg;
    logic        wrStrobe;
    logic        pushReq;
    logic        flushReq;
    logic        statusRd;
    logic [15:0] statusWord;
    logic [15:0] rdData;

    assign ioSel     = (bus.dAddr[15:2] == BASE_ADDR[15:2]);
    assign bus.ioSel = ioSel;
    assign wrSel     = ioSel && !bus.nRW;
    // Only the first cycle of a (possibly stretched) write acts.
    assign wrStrobe  = wrSel && !wrSelQReg;
    assign pushReq   = wrStrobe && !bus.dAddr[1];
    assign flushReq  = wrStrobe && bus.dAddr[1] && dData[15];
    assign statusRd  = ioSel && bus.nRW && bus.dAddr[1];

    // Bits of the bus this block deliberately ignores.
    logic unusedBits;
    assign unusedBits = &{1'b0, bus.dAddr[0], dData[14:8]};

    // Edge history of the write select, used to make long writes act once.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrSelQReg <= 1'b0;
        end else begin
            wrSelQReg <= wrSel;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtrReg, wrPtrNext;
    logic [PW-1:0] rdPtrReg, rdPtrNext;
    logic [CW-1:0] countReg, countNext;
    logic          ovfReg, ovfNext;
    logic          memWe;
    logic [PW-1:0] memWrAddr;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          pop;

    assign fifoEmpty = (countReg == '0);
    assign fifoFull  = (countReg == FIFO_FULL);

    // Pointer/count update: a flush is applied first, then the pop and the push.
    always_comb begin
        logic [PW-1:0] wrBase;
        logic [PW-1:0] rdBase;
        logic [CW-1:0] cntBase;
        logic          popEff;
        logic          pushOk;

        wrPtrNext = wrPtrReg;
        rdPtrNext = rdPtrReg;
        countNext = countReg;
        ovfNext   = ovfReg;
        memWe     = 1'b0;
        memWrAddr = wrPtrReg;

        if (flushReq) begin
            wrBase  = '0;
            rdBase  = '0;
            cntBase = '0;
        end else begin
            wrBase  = wrPtrReg;
            rdBase  = rdPtrReg;
            cntBase = countReg;
        end

        // A pop coincident with a flush is absorbed by the flush.
        popEff = pop && !flushReq;
        pushOk = pushReq && ((cntBase != FIFO_FULL) || popEff);

        wrPtrNext = wrBase;
        rdPtrNext = rdBase;
        countNext = cntBase;

        if (statusRd) begin
            ovfNext = 1'b0;
        end
        if (pushReq && !pushOk) begin
            ovfNext = 1'b1;
        end

        if (popEff) begin
            rdPtrNext = rdBase + 1'b1;
        end
        if (pushOk) begin
            memWe     = 1'b1;
            memWrAddr = wrBase;
            wrPtrNext = wrBase + 1'b1;
        end

        if (pushOk && !popEff) begin
            countNext = cntBase + 1'b1;
        end else if (!pushOk && popEff) begin
            countNext = cntBase - 1'b1;
        end
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
            ovfReg   <= 1'b0;
        end else begin
            wrPtrReg <= wrPtrNext;
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;
            ovfReg   <= ovfNext;
        end
    end

    // FIFO storage write port (contents need no reset; pointers guard them).
    always_ff @(posedge clk) begin
        if (memWe) begin
            fifoMem[memWrAddr] <= dData[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    txState_t       stateReg, stateNext;
    logic [BCW-1:0] bcReg, bcNext;
    logic [2:0]     biReg, biNext;
    logic           txdReg, txdNext;
    logic [7:0]     shReg;
    logic           shiftEn;

    // Next-state logic; txdNext is the line level for the following cycle.
    always_comb begin
        stateNext = stateReg;
        bcNext    = bcReg;
        biNext    = biReg;
        txdNext   = txdReg;
        pop       = 1'b0;
        shiftEn   = 1'b0;

        case (stateReg)
            IDLE: begin
                txdNext = 1'b1;
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    bcNext    = '0;
                    stateNext = START;
                    txdNext   = 1'b0;
                end
            end
            START: begin
                txdNext = 1'b0;
                if (bcReg == BC_LAST) begin
                    bcNext    = '0;
                    biNext    = 3'd0;
                    stateNext = DATA;
                    txdNext   = shReg[0];
                end else begin
                    bcNext = bcReg + 1'b1;
                end
            end
            DATA: begin
                txdNext = shReg[0];
                if (bcReg == BC_LAST) begin
                    bcNext  = '0;
                    shiftEn = 1'b1;
                    if (biReg == 3'd7) begin
                        stateNext = STOP;
                        txdNext   = 1'b1;
                    end else begin
                        biNext  = biReg + 1'b1;
                        txdNext = shReg[1];
                    end
                end else begin
                    bcNext = bcReg + 1'b1;
                end
            end
            STOP: begin
                txdNext = 1'b1;
                if (bcReg == BC_LAST) begin
                    bcNext = '0;
                    if (!fifoEmpty) begin
                        // Back-to-back frame: no idle bit between stop and start.
                        pop       = 1'b1;
                        stateNext = START;
                        txdNext   = 1'b0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    bcNext = bcReg + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                txdNext   = 1'b1;
            end
        endcase
    end

    // FSM state, baud/bit counters and the registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            bcReg    <= '0;
            biReg    <= 3'd0;
            txdReg   <= 1'b1;
        end else begin
            stateReg <= stateNext;
            bcReg    <= bcNext;
            biReg    <= biNext;
            txdReg   <= txdNext;
        end
    end

    // Shift register: loaded by a registered FIFO read on pop, shifted per data bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shReg <= 8'h00;
        end else if (pop) begin
            shReg <= fifoMem[rdPtrReg];
        end else if (shiftEn) begin
            shReg <= {1'b0, shReg[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Outputs and read data
    // ------------------------------------------------------------------
    logic [2:0] cntSat;

    // STATUS count field saturates at 7 for deeper FIFOs.
    always_comb begin
        cntSat = 3'(countReg);
        if (32'(countReg) > 7) begin
            cntSat = 3'd7;
        end
    end

    assign txd        = txdReg;
    assign txBusy     = !fifoEmpty || (stateReg != IDLE);
    assign statusWord = {8'h00, 1'b0, cntSat, ovfReg, txBusy, fifoEmpty, fifoFull};
    assign rdData     = bus.dAddr[1] ? statusWord : 16'h0000;
    assign dData      = (ioSel && bus.nRW) ? rdData : 16'hzzzz;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx: stores push expected bytes into a
// scoreboard queue, a line monitor decodes every txd frame and compares it
// against the queue, and the main sequence checks timing and STATUS.
module tb_dbus_uart_tx;
    localparam int BAUD = 16;
    localparam logic [15:0] TXDATA = 16'hFF00;
    localparam logic [15:0] STATUS = 16'hFF02;

    logic        clk = 1'b0;
    logic        reset;
    wire  [15:0] dData;
    logic [15:0] tbData;
    logic        tbDrive;
    logic        txd;
    logic        txBusy;

    dbus_uart_tx_if bus ();

    assign dData = tbDrive ? tbData : 16'hzzzz;

    dbus_uart_tx #(
        .BASE_ADDR (16'hFF00),
        .BAUD_DIV  (BAUD),
        .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dData (dData),
        .txd   (txd),
        .txBusy(txBusy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] expQ[$];
    int         startQ[$];
    int         frameCount = 0;
    int         cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame monitor: samples txd mid-bit on the falling edge.
    int         monCnt;
    bit         monActive = 1'b0;
    logic [7:0] monByte;
    always @(negedge clk) begin
        int bitIdx;
        if (reset === 1'b1) begin
            monActive = 1'b0;
        end else if (!monActive) begin
            if (txd === 1'b0) begin
                monActive = 1'b1;
                monCnt    = 0;
                startQ.push_back(cyc);
            end
        end else begin
            monCnt++;
        end
        if (reset !== 1'b1 && monActive && (monCnt % BAUD) == BAUD / 2) begin
            bitIdx = monCnt / BAUD;
            if (bitIdx == 0) begin
                chk("start_bit", 32'(txd), 32'd0);
            end else if (bitIdx <= 8) begin
                monByte[bitIdx-1] = txd;
            end else begin
                chk("stop_bit", 32'(txd), 32'd1);
                frameCount++;
                chk("frame_expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    chk("frame_byte", 32'(monByte), 32'(expQ.pop_front()));
                end
                $display("frame %0d: byte=0x%02h at cycle %0d", frameCount, monByte, cyc);
                monActive = 1'b0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busIdle();
        bus.dAddr = 16'h0000;
        bus.nRW   = 1'b1;
        tbDrive   = 1'b0;
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        bus.dAddr = addr;
        bus.nRW   = 1'b0;
        tbData    = data;
        tbDrive   = 1'b1;
        tick();
        busIdle();
        $display("write addr=0x%04h data=0x%04h", addr, data);
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] v);
        bus.dAddr = addr;
        bus.nRW   = 1'b1;
        tbDrive   = 1'b0;
        #1;
        v = dData;
        tick();
        busIdle();
        $display("read  addr=0x%04h data=0x%04h", addr, v);
    endtask

    // One store to TXDATA followed by one idle cycle; accepted bytes are expected.
    task automatic store(input logic [7:0] b, input bit accepted);
        busWrite(TXDATA, {8'h00, b});
        if (accepted) expQ.push_back(b);
        tick();
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (txBusy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(n >= budget), 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        logic [15:0] rd;
        logic        txdLog[200];
        logic        busyLog[200];
        int          fc0, sq0, lowRun, fallAt, lowCnt;

        reset = 1'b1;
        busIdle();
        tbData = 16'h0000;
        repeat (5) tick();
        reset = 1'b0;

        // 1: reset state, idle line, STATUS after reset
        repeat (50) tick();
        chk("idle_txd", 32'(txd), 32'd1);
        chk("idle_busy", 32'(txBusy), 32'd0);
        busRead(STATUS, rd);
        chk("reset_status", 32'(rd), 32'h0002);
        busRead(TXDATA, rd);
        chk("txdata_read", 32'(rd), 32'h0000);
        bus.dAddr = 16'h1234;
        bus.nRW   = 1'b0;
        tbData    = 16'h0077;
        tbDrive   = 1'b1;
        #1;
        chk("outside_iosel", 32'(bus.ioSel), 32'd0);
        tick();
        busIdle();
        tick();
        busRead(STATUS, rd);
        chk("outside_no_push", 32'(rd), 32'h0002);

        // 2: single frame timing
        fc0 = frameCount;
        busWrite(TXDATA, 16'h0055);
        expQ.push_back(8'h55);
        chk("txd_high_1clk_after", 32'(txd), 32'd1);
        for (int t = 0; t < 200; t++) begin
            tick();
            txdLog[t]  = txd;
            busyLog[t] = txBusy;
        end
        lowRun = 0;
        while (lowRun < 200 && txdLog[lowRun] == 1'b0) lowRun++;
        chk("start_low_len", 32'(lowRun), 32'(BAUD));
        fallAt = 0;
        while (fallAt < 200 && busyLog[fallAt] == 1'b1) fallAt++;
        chk("frame_len", 32'(fallAt), 32'(10 * BAUD));
        chk("frame_count_1", 32'(frameCount - fc0), 32'd1);

        // 3: five back-to-back stores, all accepted, no idle gap
        fc0 = frameCount;
        sq0 = startQ.size();
        for (int i = 0; i < 5; i++) store(8'(8'h30 + i), 1'b1);
        busRead(STATUS, rd);
        chk("five_status", 32'(rd), 32'h0045);
        waitIdle(6 * 10 * BAUD);
        chk("five_frames", 32'(frameCount - fc0), 32'd5);
        for (int i = 0; i < 4; i++) begin
            if (startQ.size() > sq0 + i + 1)
                chk("no_gap", 32'(startQ[sq0+i+1] - startQ[sq0+i]), 32'(10 * BAUD));
            else
                chk("no_gap_missing", 32'(startQ.size()), 32'(sq0 + 5));
        end
        busRead(STATUS, rd);
        chk("five_no_ovf", 32'(rd), 32'h0002);

        // 4: six stores, sixth dropped, sticky ovf cleared by a STATUS read
        fc0 = frameCount;
        for (int i = 0; i < 6; i++) store(8'(8'hA0 + i), i < 5);
        busRead(STATUS, rd);
        chk("ovf_set", 32'(rd), 32'h004D);
        busRead(STATUS, rd);
        chk("ovf_cleared", 32'(rd), 32'h0045);
        waitIdle(6 * 10 * BAUD);
        chk("six_frames", 32'(frameCount - fc0), 32'd5);

        // 5: write held for three cycles pushes once
        fc0 = frameCount;
        store(8'h11, 1'b1);
        bus.dAddr = TXDATA;
        bus.nRW   = 1'b0;
        tbData    = 16'h00A5;
        tbDrive   = 1'b1;
        #1;
        chk("hold_iosel", 32'(bus.ioSel), 32'd1);
        repeat (3) tick();
        busIdle();
        expQ.push_back(8'hA5);
        busRead(STATUS, rd);
        chk("hold_one_push", 32'(rd), 32'h0014);
        waitIdle(4 * 10 * BAUD);
        chk("hold_frames", 32'(frameCount - fc0), 32'd2);

        // Flush: queued bytes discarded, in-flight frame completes
        fc0 = frameCount;
        store(8'h3C, 1'b1);
        store(8'h01, 1'b1);
        store(8'h02, 1'b1);
        busWrite(STATUS, 16'h8000);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        busRead(STATUS, rd);
        chk("flush_status", 32'(rd), 32'h0006);
        waitIdle(3 * 10 * BAUD);
        chk("flush_frames", 32'(frameCount - fc0), 32'd1);

        // 6: reset in the middle of the data bits with two bytes queued
        store(8'h00, 1'b1);
        store(8'hB2, 1'b1);
        store(8'hB3, 1'b1);
        repeat (60) tick();
        chk("mid_data_low", 32'(txd), 32'd0);
        reset = 1'b1;
        tick();
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_busy", 32'(txBusy), 32'd0);
        reset = 1'b0;
        expQ.delete();
        busRead(STATUS, rd);
        chk("reset_status_mid", 32'(rd), 32'h0002);
        fc0    = frameCount;
        lowCnt = 0;
        for (int t = 0; t < 400; t++) begin
            tick();
            if (txd !== 1'b1) lowCnt++;
        end
        chk("no_frames_after_reset", 32'(frameCount - fc0), 32'd0);
        chk("line_stays_high", 32'(lowCnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
